caravel_la_fir_selftest: RTL and testbench

// Chip-level self-test stand-in for the Caravel counter_la_fir flow: runs a fixed 11-tap FIR over a fixed ramp.

---
 rtl/caravel_la_fir_selftest.sv | 166 ++++++++++++++++
 tb/tb_caravel_la_fir_selftest.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/caravel_la_fir_selftest.sv
// Chip-level self-test stand-in: fixed 11-tap FIR over a ramp, progress on
// checkbits mprj_io[31:16], completion message "OK\n" on UART pin mprj_io[6].
module caravel_la_fir_selftest #(
  parameter int START_DELAY = 1000,
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_SAMPLES = 64,
  parameter int BAUD_DIV    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [37:0] mprj_io_in,
  output logic [37:0] mprj_io_out,
  output logic [37:0] mprj_io_oeb,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, START, LOAD, MAC, SHOW, DONE} state_t;

  state_t             state;
  logic [31:0]        cnt;
  logic [10:0]        n;
  logic [3:0]         k;
  logic [10:0]        hist [11];
  logic signed [31:0] acc;
  logic signed [31:0] acc_next;
  logic signed [31:0] tap_k;
  logic signed [31:0] hist_k;
  logic [15:0]        checkbits;
  logic               uart_tx;
  logic               uart_active;
  logic [1:0]         byte_idx;
  logic [3:0]         bit_idx;
  logic [31:0]        baud_cnt;
  logic [7:0]         cur_byte;
  logic               pause;
  logic               unused_in;

  assign pause     = mprj_io_in[0];
  assign unused_in = ^mprj_io_in[37:1];

  function automatic logic signed [31:0] tap(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd9: tap = -32'sd10;
      4'd2, 4'd8: tap = -32'sd9;
      4'd3, 4'd7: tap = 32'sd23;
      4'd4, 4'd6: tap = 32'sd56;
      4'd5:       tap = 32'sd63;
      default:    tap = 32'sd0;
    endcase
  endfunction

  // MAC datapath and current UART byte selection
  always_comb begin
    tap_k    = tap(k);
    hist_k   = signed'({21'd0, hist[k]});
    acc_next = acc + tap_k * hist_k;
    case (byte_idx)
      2'd0:    cur_byte = 8'h4F;
      2'd1:    cur_byte = 8'h4B;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Sequencer, FIR datapath and UART transmitter; everything freezes on pause
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      n           <= '0;
      k           <= '0;
      acc         <= '0;
      checkbits   <= '0;
      uart_tx     <= 1'b1;
      uart_active <= 1'b0;
      byte_idx    <= '0;
      bit_idx     <= '0;
      baud_cnt    <= '0;
      done        <= 1'b0;
      for (int unsigned i = 0; i < 11; i++) hist[i] <= '0;
    end else if (!pause) begin
      case (state)
        IDLE: begin
          if (cnt == 32'(START_DELAY - 1)) begin
            cnt       <= '0;
            state     <= START;
            checkbits <= 16'hAB40;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        START: begin
          if (cnt == 32'(HOLD_CYCLES - 1)) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        LOAD: begin
          hist[0] <= n + 11'd1;
          for (int unsigned i = 1; i < 11; i++) hist[i] <= hist[i-1];
          acc   <= '0;
          k     <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          if (k == 4'd10) begin
            // the final product is folded in here so the sum shows without an extra cycle
            checkbits <= acc_next[15:0];
            cnt       <= '0;
            state     <= SHOW;
          end else begin
            k <= k + 4'd1;
          end
        end
        SHOW: begin
          if (cnt == 32'(HOLD_CYCLES - 1)) begin
            cnt <= '0;
            if (n == 11'(NUM_SAMPLES - 1)) begin
              state       <= DONE;
              checkbits   <= 16'hAB51;
              uart_active <= 1'b1;
              uart_tx     <= 1'b0;
              byte_idx    <= '0;
              bit_idx     <= '0;
              baud_cnt    <= '0;
            end else begin
              n     <= n + 11'd1;
              state <= LOAD;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase

      // bit_idx 0 = start, 1..8 = data LSB first, 9 = stop
      if (uart_active) begin
        if (baud_cnt == 32'(BAUD_DIV - 1)) begin
          baud_cnt <= '0;
          if (bit_idx == 4'd9) begin
            if (byte_idx == 2'd2) begin
              uart_active <= 1'b0;
              done        <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              bit_idx  <= '0;
              uart_tx  <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 4'd1;
            uart_tx <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
          end
        end else begin
          baud_cnt <= baud_cnt + 32'd1;
        end
      end
    end
  end

  assign mprj_io_out = {6'd0, checkbits, 9'd0, uart_tx, 6'd0};
  assign mprj_io_oeb = {6'h3F, 16'h0000, 9'h1FF, 1'b0, 6'h3F};

endmodule

// File: tb/tb_caravel_la_fir_selftest.sv
// Directed bench for caravel_la_fir_selftest with short delay/hold settings.
module tb_caravel_la_fir_selftest;

  localparam int SD   = 10;
  localparam int HOLD = 4;
  localparam int NS   = 64;
  localparam int BAUD = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] mprj_io_in = '0;
  logic [37:0] mprj_io_out;
  logic [37:0] mprj_io_oeb;
  logic        done;

  int checks = 0;
  int passes = 0;

  caravel_la_fir_selftest #(
    .START_DELAY(SD),
    .HOLD_CYCLES(HOLD),
    .NUM_SAMPLES(NS),
    .BAUD_DIV(BAUD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mprj_io_in(mprj_io_in),
    .mprj_io_out(mprj_io_out),
    .mprj_io_oeb(mprj_io_oeb),
    .done(done)
  );

  always #5 clock = ~clock;

  wire [15:0] checkbits = mprj_io_out[31:16];
  wire        uart_tx   = mprj_io_out[6];

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference FIR: direct convolution over the ramp x[n]=n+1
  function automatic logic [15:0] yref(input int idx);
    int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int s = 0;
    for (int j = 0; j < 11; j++)
      if (idx - j >= 0) s += taps[j] * (idx - j + 1);
    return 16'(s);
  endfunction

  initial begin
    int          cyc;
    int          bad;
    logic [15:0] v0, v1, hold_val;
    logic [9:0]  frame;

    // ---- reset state ----
    step(3);
    check("reset_checkbits", checkbits, 16'h0000);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_done", done, 1'b0);
    check("oeb_const", mprj_io_oeb, 38'h3F_0000_FFBF);
    check("unused_out_zero", mprj_io_out & ~38'h00_FFFF_0040, 38'h0);

    // ---- idle delay then start marker ----
    reset = 1'b0;
    cyc = 0;
    while (checkbits != 16'hAB40 && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("idle_cycles_before_ab40", cyc, SD);

    // AB40 stays through START (HOLD) plus the first LOAD/MAC (12)
    cyc = 0;
    while (checkbits == 16'hAB40 && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("ab40_visible_cycles", cyc, HOLD + 12);

    // ---- hand-computed samples ----
    check("y0", checkbits, 16'h0000);
    step(16);
    check("y1", checkbits, 16'hFFF6);
    step(16);
    check("y2", checkbits, 16'hFFE3);
    step(16 * 8);
    check("y10", checkbits, 16'h044A);
    step(16);
    check("y11_steady", checkbits, 16'(183 * 7));

    // ---- remaining samples against the model, with held-value and idle-UART checks ----
    bad = 0;
    for (int i = 11; i < NS; i++) begin
      v0 = checkbits;
      if (uart_tx !== 1'b1 || done !== 1'b0) bad++;
      step(HOLD - 1);
      v1 = checkbits;
      check($sformatf("y%0d", i), v0, yref(i));
      check($sformatf("y%0d_held", i), v1, yref(i));
      if (i != NS - 1) step(16 - (HOLD - 1));
    end
    check("y63_last", v1, 16'h2A2D);
    check("uart_idle_before_done", bad, 0);

    // ---- end marker and UART message ----
    step(1);
    check("ab51_marker", checkbits, 16'hAB51);
    check("uart_start_at_done_entry", uart_tx, 1'b0);
    step(BAUD / 2);
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 10; j++) begin
        frame[j] = uart_tx;
        if (!(b == 2 && j == 9)) step(BAUD);
      end
      check($sformatf("uart_b%0d_start", b), frame[0], 1'b0);
      check($sformatf("uart_b%0d_stop", b), frame[9], 1'b1);
      check($sformatf("uart_b%0d_data", b), frame[8:1], (b == 0) ? 8'h4F : (b == 1) ? 8'h4B : 8'h0A);
    end
    check("done_low_in_last_stop", done, 1'b0);
    step(BAUD / 2 - 1);
    check("done_low_last_stop_cycle", done, 1'b0);
    step(1);
    check("done_after_stop", done, 1'b1);
    step(40);
    check("done_sticky", done, 1'b1);
    check("uart_idle_after", uart_tx, 1'b1);
    check("ab51_held", checkbits, 16'hAB51);

    // ---- pause in MAC of sample 6, then reset mid-SHOW ----
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(115);
    hold_val = checkbits;
    check("pre_pause_y5", hold_val, yref(5));
    mprj_io_in[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (checkbits !== hold_val || uart_tx !== 1'b1 || done !== 1'b0) bad++;
    end
    check("outputs_frozen_in_pause", bad, 0);
    mprj_io_in[0] = 1'b0;
    step(6);
    check("resume_still_y5", checkbits, yref(5));
    step(1);
    check("resume_y6", checkbits, yref(6));
    step(1);
    reset = 1'b1;
    mprj_io_in[0] = 1'b1;
    step(1);
    check("reset_over_pause_checkbits", checkbits, 16'h0000);
    check("reset_over_pause_uart", uart_tx, 1'b1);
    check("reset_over_pause_done", done, 1'b0);
    reset = 1'b0;
    mprj_io_in[0] = 1'b0;
    cyc = 0;
    while (checkbits != 16'hAB40 && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("restart_idle_cycles", cyc, SD);
    step(16);
    check("restart_y0", checkbits, 16'h0000);
    step(16);
    check("restart_y1", checkbits, 16'hFFF6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
